paralelo_serial: RTL
====================

# paralelo_serial

Transmit-side PHY block. Accepts bytes over a valid/ready handshake and shifts them out MSB-first, one bit per clk_32f cycle. After reset it sends a fixed run of 0xBC comma bytes so the far-end serial-to-parallel receiver can lock. In operation, any byte slot with no data is filled with 0xBC idle. It sits between the lane/byte logic and the serial line, mirroring the receive-side deserializer.

## Interface
Parameters:
- BC_COUNT, 4: number of comma bytes sent after reset before data is accepted; range 1–15.
- COMMA, 8'hBC: idle/comma byte value.

Ports:
- clk_32f  input  1  bit-rate clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- data_in  input  8  byte to transmit.
- valid_in  input  1  data_in holds a byte to send.
- ready_out  output  1  block accepts data_in at this edge.
- data_out  output  1  serial line, registered.
- active_out  output  1  sync sequence complete; block is in RUN.

## Operation
- State: 3-bit bit_cnt, 8-bit shift_reg, 4-bit bc_cnt, and FSM state SYNC/RUN.
- Reset values: data_out=0, active_out=0, shift_reg=0, bit_cnt=0, bc_cnt=0, state=SYNC.
- bit_cnt increments every non-reset cycle and wraps 7→0.
- **Load edge** (bit_cnt==0):
  - next_byte is chosen and data_out<=next_byte[7].
  - shift_reg<={next_byte[6:0],1'b0}.
- **Other edges**: data_out<=shift_reg[7]; shift_reg<=shift_reg<<1.
- next_byte selection:
  - SYNC: always COMMA; valid_in is ignored.
  - RUN: data_in if valid_in, else COMMA.
- ready_out is combinational: (state==RUN) && (bit_cnt==0). Transfer happens on an edge where valid_in && ready_out. The producer holds data_in/valid_in until a transfer occurs.
- SYNC→RUN: on a SYNC load edge, bc_cnt<=bc_cnt+1. When the incremented value equals BC_COUNT, state<=RUN in the same edge.
- RUN has no exit except reset. bc_cnt freezes in RUN.
- active_out is registered and equals (state==RUN).
- A data byte equal to COMMA is sent unchanged. It is indistinguishable from idle on the line; this is a documented limitation, not an error.
- Reset asserted mid-byte: the current byte is truncated. Edge behaviour and restart are defined in Timing.

## Timing
- Cycle n = n-th rising edge with reset low; n=0 is the first edge after reset drops.
- After edge n, data_out carries bit 7−(n mod 8) of the byte loaded at edge 8·⌊n/8⌋.
- With BC_COUNT=4:
  - Commas are loaded at edges 0, 8, 16, 24.
  - state and active_out change to RUN at edge 24.
  - ready_out first goes high in the cycle before edge 32.
  - The first data byte is loaded at edge 32.
- Latency: a byte accepted at edge E appears on data_out after edges E..E+7, MSB first.
- Back-to-back bytes: one transfer per 8 cycles, with no gap bits.
- ready_out is high exactly 1 cycle in 8 while in RUN, and never in SYNC or during reset.
- Reset asserted at any edge:
  - At that edge, data_out<=0 and active_out<=0.
  - On release, the full BC_COUNT comma sequence restarts at n=0.
- A valid_in change mid-byte has no effect until the next load edge.

## Structure
- Shared package/header phy_pkg:
  - COMMA_BYTE = 8'hBC
  - BYTE_W = 8
  - default BC_COUNT = 4
  - FSM state encodings SYNC=1'b0, RUN=1'b1
- The receive-side block uses the same COMMA_BYTE and BC_COUNT.
- No sub-module is required; bit_cnt, shift_reg and the FSM live in one module.
- A separate contador_mod8 may be factored out if the receive side reuses it.

## Test plan
- Reset 3 cycles, then release with valid_in=0:
  - data_out=0 and active_out=0 during reset.
  - Then 1011_1100 repeated 4 times (32 bits).
  - active_out rises after edge 24; ready_out is first high before edge 32; commas continue after that.
- valid_in=1, data_in=8'h5A held from reset release: after 4 commas, data_out=0101_1010 at edges 32–39. ready_out accepts exactly once per 8 cycles.
- Back-to-back 8'h01, 8'hFF, 8'h80, each presented at its ready cycle: contiguous 24 bits 0000_0001 1111_1111 1000_0000 with no inserted bits.
- In RUN, valid_in=0 for one slot between 8'hA5 and 8'h3C: serial is 1010_0101, 1011_1100, 0011_1100, and active_out stays 1.
- Reset asserted while bit 3 of 8'hA5 is on the line:
  - Next edge: data_out=0, active_out=0.
  - After release, 4 full commas before ready_out, and no leftover A5 bits.
- data_in=8'hBC with valid_in=1 in RUN: accepted normally (ready&&valid), serial 1011_1100, no state change.

Source files
------------

// File: rtl/phy_pkg.sv
// Shared PHY constants and state encoding for the serializer/deserializer pair.
// Latency: none (declarations only).
// Backpressure: not applicable.
package phy_pkg;

    // Idle / comma symbol used for lock and for empty byte slots.
    localparam logic [7:0] COMMA_BYTE = 8'hBC;

    // Width of one line symbol in bits.
    localparam int BYTE_W = 8;

    // Number of comma bytes sent after reset before data is accepted.
    localparam int BC_COUNT_DEF = 4;

    // Link state: SYNC while sending the lock preamble, RUN afterwards.
    typedef enum logic {
        SYNC = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/paralelo_serial_contador.sv
// Free-running modulo-8 bit-slot counter shared by the serializer and deserializer.
// Latency: count advances one step per clk_32f edge, wraps 7 -> 0.
// Backpressure: none; always counts while reset is low.
module contador_mod8 (
    input  logic       clk,
    input  logic       reset,
    output logic [2:0] count
);

    // Bit position within the current byte slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= 3'd0;
        end else begin
            count <= count + 3'd1;
        end
    end

endmodule

// File: rtl/paralelo_serial.sv
// Byte-to-serial transmitter: sends a comma preamble, then MSB-first bytes with idle fill.
// Latency: byte accepted at edge E drives data_out after edges E..E+7.
// Backpressure: ready_out high one cycle in eight in RUN; producer holds until accepted.
module paralelo_serial
    import phy_pkg::*;
#(
    parameter int         BC_COUNT = BC_COUNT_DEF,
    parameter logic [7:0] COMMA    = COMMA_BYTE
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       data_out,
    output logic       active_out
);

    logic [2:0]        bit_cnt;
    logic [BYTE_W-1:0] shift_reg;
    logic [3:0]        bc_cnt;
    logic [3:0]        bc_cnt_nxt;
    state_t            state;
    state_t            state_nxt;
    logic [BYTE_W-1:0] next_byte;
    logic              load;

    contador_mod8 u_bit_cnt (
        .clk   (clk_32f),
        .reset (reset),
        .count (bit_cnt)
    );

    assign load = (bit_cnt == 3'd0);

    // Next-state, comma counting, byte selection and the combinational ready.
    // Ready is masked during reset so no byte can be consumed at a reset edge.
    always_comb begin
        state_nxt  = state;
        bc_cnt_nxt = bc_cnt;
        next_byte  = COMMA;
        ready_out  = 1'b0;
        case (state)
            SYNC: begin
                if (load) begin
                    bc_cnt_nxt = bc_cnt + 4'd1;
                    if (bc_cnt_nxt == 4'(BC_COUNT)) begin
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                ready_out = load && !reset;
                if (valid_in) begin
                    next_byte = data_in;
                end
            end
            default: begin
                state_nxt = SYNC;
            end
        endcase
    end

    // Registered FSM state, shifter and serial/active outputs.
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state      <= SYNC;
            bc_cnt     <= 4'd0;
            shift_reg  <= '0;
            data_out   <= 1'b0;
            active_out <= 1'b0;
        end else begin
            state      <= state_nxt;
            bc_cnt     <= bc_cnt_nxt;
            active_out <= (state_nxt == RUN);
            if (load) begin
                data_out  <= next_byte[BYTE_W-1];
                shift_reg <= {next_byte[BYTE_W-2:0], 1'b0};
            end else begin
                data_out  <= shift_reg[BYTE_W-1];
                shift_reg <= {shift_reg[BYTE_W-2:0], 1'b0};
            end
        end
    end

endmodule
